// File: rtl/arbitro_rr_4.sv
// Four-requester round-robin arbiter with bounded ownership time.
// Drives the registered one-hot grant, the S0/S1 select pair and the selected data bit F.
module arbitro_rr_4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] x,
    output logic [3:0] gnt,
    output logic       S0,
    output logic       S1,
    output logic       busy,
    output logic       F
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state_r;
    logic [1:0] last_r;
    logic [7:0] hold_cnt_r;
    logic [3:0] gnt_r;
    logic       s0_r;
    logic       s1_r;
    logic       busy_r;

    state_t     nxt_state_s;
    logic [1:0] nxt_last_s;
    logic [7:0] nxt_cnt_s;
    logic [2:0] pick_s;
    logic [3:0] own_mask_s;
    logic       owner_req_s;
    logic       others_s;
    logic       pair_lo_s;
    logic       pair_hi_s;

    // Scan base+1, base+2, base+3, base (mod 4); returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            cand = base + k[1:0];
            if (!res[2] && r[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Search context: scanning from the current owner puts it last, so it only wins when alone.
    always_comb begin
        own_mask_s  = 4'b0001 << last_r;
        owner_req_s = |(req & own_mask_s);
        others_s    = |(req & ~own_mask_s);
        pick_s      = rr_pick(req, last_r);
    end

    // Next-state decision for ownership, hand-over and hold counting.
    always_comb begin
        nxt_state_s = state_r;
        nxt_last_s  = last_r;
        nxt_cnt_s   = hold_cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_s[2]) begin
                    nxt_state_s = OWN;
                    nxt_last_s  = pick_s[1:0];
                    nxt_cnt_s   = 8'd0;
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            OWN: begin
                if (!owner_req_s) begin
                    if (pick_s[2]) begin
                        nxt_last_s = pick_s[1:0];
                        nxt_cnt_s  = 8'd0;
                    end else begin
                        nxt_state_s = IDLE;
                        nxt_cnt_s   = 8'd0;
                    end
                end else if (others_s) begin
                    if (hold_cnt_r >= HOLD_LAST) begin
                        nxt_last_s = pick_s[1:0];
                        nxt_cnt_s  = 8'd0;
                    end else begin
                        nxt_cnt_s = hold_cnt_r + 8'd1;
                    end
                end else begin
                    // Lone owner: count saturates so a newcomer preempts on its first edge.
                    if (hold_cnt_r < HOLD_LAST) begin
                        nxt_cnt_s = hold_cnt_r + 8'd1;
                    end else begin
                        nxt_cnt_s = hold_cnt_r;
                    end
                end
            end
            default: begin
                nxt_state_s = IDLE;
                nxt_cnt_s   = 8'd0;
            end
        endcase
    end

    // State and registered outputs; selects come from the registered owner index only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            last_r     <= 2'd3;
            hold_cnt_r <= 8'd0;
            gnt_r      <= 4'b0000;
            s0_r       <= 1'b0;
            s1_r       <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= nxt_state_s;
            last_r     <= nxt_last_s;
            hold_cnt_r <= nxt_cnt_s;
            if (nxt_state_s == OWN) begin
                gnt_r  <= 4'b0001 << nxt_last_s;
                s0_r   <= nxt_last_s[1];
                s1_r   <= nxt_last_s[0];
                busy_r <= 1'b1;
            end else begin
                gnt_r  <= 4'b0000;
                s0_r   <= 1'b0;
                s1_r   <= 1'b0;
                busy_r <= 1'b0;
            end
        end
    end

    // Two-level 2:1 data path gated by busy.
    always_comb begin
        pair_lo_s = s1_r ? x[1] : x[0];
        pair_hi_s = s1_r ? x[3] : x[2];
        F         = (s0_r ? pair_hi_s : pair_lo_s) & busy_r;
    end

    assign gnt  = gnt_r;
    assign S0   = s0_r;
    assign S1   = s1_r;
    assign busy = busy_r;

endmodule

// File: doc/arbitro_rr_4.md
# arbitro_rr_4

Four-requester round-robin arbiter that owns the select lines of the shared 4-to-1 selector. It decides which of four sources drives the shared output bit `F` and for how long. It produces a registered one-hot grant and the matching `S0`/`S1` select pair, and it forwards the granted source's data bit to `F`. It enforces a bounded ownership time so no requester can monopolise the shared path while others wait.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive grant cycles for one owner while others are waiting. Legal range 1..255.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 4: request per source. Held high for as long as the source wants the path.
- `x` in 4: data bit per source. `x[i]` belongs to requester i.
- `gnt` out 4: registered one-hot grant, or all-zero.
- `S0` out 1: pair select. Equals bit 1 of the granted index.
- `S1` out 1: in-pair select. Equals bit 0 of the granted index.
- `busy` out 1: high when any grant is active (`busy = |gnt`).
- `F` out 1: combinational output. Equals `x[idx]` when `busy` is high, 0 when idle.

## Operation
- Index mapping for the selects: 0→`S0S1`=00, 1→01, 2→10, 3→11.
- Internal state:
  - `last`: 2 bits, index of the previous owner.
  - `hold_cnt`: 8 bits.
  - `state`: IDLE or OWN.
- Round-robin search: scan indices `last+1`, `last+2`, `last+3`, `last` (mod 4). Pick the first index with `req` high.
- In IDLE:
  - If any `req` is high, grant the search winner. Go to OWN, set `last` to the winner, clear `hold_cnt`.
  - Otherwise stay in IDLE.
- In OWN with owner o:
  - If `req[o]` = 0 and other requests are pending: grant the next search winner on the same edge. There is no idle cycle.
  - If `req[o]` = 0 and nothing is pending: go to IDLE, `gnt` = 0.
  - If `req[o]` = 1, `hold_cnt` = `HOLD_MAX`-1, and another `req` is high: preempt. Grant the next search winner and clear `hold_cnt`.
  - If `req[o]` = 1 and no other request is pending: keep the grant. `hold_cnt` saturates at `HOLD_MAX`-1.
  - Otherwise keep the grant and increment `hold_cnt`.
- The search always excludes o when o is being released or preempted, unless o is the only requester.
- `S0`/`S1` are driven from the registered grant index, not from `req`, so the selects never glitch mid-cycle.
- When idle, `S0`/`S1` hold 00.
- The data path is a 2-level 2:1 structure:
  - `S1` picks within the pairs {0,1} and {2,3}.
  - `S0` picks the pair.
  - The result is ANDed with `busy`.

## Timing
- Reset (async, `rst_n` low) immediately forces:
  - `gnt` = 0000, `busy` = 0, `S0` = `S1` = 0, `F` = 0.
  - `state` = IDLE, `hold_cnt` = 0.
  - `last` = 3, so index 0 has first priority after reset.
- Reset asserted mid-grant drops the grant in the same cycle, without waiting for a clock edge. Pending requests are re-arbitrated from `last` = 3 after release.
- Request-to-grant latency is 1 cycle. A `req` high at edge k gives `gnt` at edge k (registered) and visible through cycle k+1.
- Release latency is 1 cycle. Owner `req` low sampled at edge k gives `gnt[o]` low after edge k.
- Ownership bound: with contention, an owner keeps `gnt` for exactly `HOLD_MAX` consecutive cycles.
- `HOLD_MAX` = 1: pure round-robin with one cycle per grant under full load.
- Simultaneous owner release and preemption at the same edge: both select the same next winner, so the result is identical.
- `F` is combinational from `x` and the registered state, with zero-cycle latency.

## Test plan
- **Reset:** `rst_n`=0 with `req`=1111, `x`=1111 → `gnt`=0000, `S0S1`=00, `busy`=0, `F`=0. No clock is needed.
- **Single request:** `req`=0100 from cycle 0, `x`=0100 → from the first edge, `gnt`=0100, `S0S1`=10, `busy`=1, `F`=1. Then drop `req`, and `gnt`=0000 one edge later.
- **Full load:** `HOLD_MAX`=4, `req`=1111 held → grants are 0001, 0010, 0100, 1000, 0001, each lasting exactly 4 cycles, with no gap between grants.
- **Early release:** owner 0 drops `req` at cycle 2 while `req[3]`=1 → `gnt` goes from 0001 to 1000 on the next edge, `busy` never goes low, and `S0S1` goes to 11.
- **Lone owner:** `HOLD_MAX`=2, only `req[1]`=1 for 20 cycles → `gnt`=0010 for the whole period. When `req[2]` rises at cycle 20, `gnt` becomes 0100 within 1 edge, because `hold_cnt` was saturated.
- **Reset mid-grant:** owner 2 is granted and `rst_n` pulses low mid-cycle → outputs clear immediately. After release with `req`=1010, the first grant is 0010 (priority restarts at index 0).
